// File: rtl/fust_pkg.sv
// fust_pkg: shared types and constants for the functional-unit status table.
package fust_pkg;
  localparam int FUST_NUM_FU  = 5;
  localparam int FUST_NUM_SRC = 3;
  localparam int FUST_OP_W    = 8;
  localparam int FUST_REG_W   = 5;
  localparam int FUST_TAG_W   = $clog2(FUST_NUM_FU + 1);
  localparam int TAG_READY    = 0;
  typedef enum logic [1:0] {
    FUST_IDLE   = 2'd0,
    FUST_WAIT   = 2'd1,
    FUST_READY  = 2'd2,
    FUST_ISSUED = 2'd3
  } fust_state_e;
  typedef struct packed {
    logic                                       busy;
    logic                                       issued;
    logic                                       spec;
    logic [FUST_OP_W-1:0]                       op;
    logic [FUST_REG_W-1:0]                      rd;
    logic [FUST_NUM_SRC-1:0][FUST_TAG_W-1:0]    tags;
  } fust_row_t;
endpackage

// File: rtl/fust_issue_select.sv
// fust_issue_select: grants up to ISSUE_W requests, lowest index first.
module fust_issue_select #(
  parameter int NUM_FU  = 5,
  parameter int ISSUE_W = 2
) (
  input  logic [NUM_FU-1:0] req,
  output logic [NUM_FU-1:0] gnt
);
  int cnt;
  always_comb begin
    gnt = '0;
    cnt = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      gnt[i] = req[i] && (cnt < ISSUE_W);
      cnt    = cnt + (gnt[i] ? 1 : 0);
    end
  end
endmodule

// File: rtl/fu_status_table.sv
// fu_status_table: per-FU row tracking with tag wakeup, width-limited issue and branch squash.
module fu_status_table
  import fust_pkg::*;
#(
  parameter  int NUM_FU  = FUST_NUM_FU,
  parameter  int NUM_SRC = FUST_NUM_SRC,
  parameter  int OP_W    = FUST_OP_W,
  parameter  int REG_W   = FUST_REG_W,
  parameter  int ISSUE_W = 2,
  localparam int FU_W    = $clog2(NUM_FU),
  localparam int TAG_W   = $clog2(NUM_FU + 1)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     dispatch_en,
  input  logic [FU_W-1:0]          dispatch_fu,
  input  logic [OP_W-1:0]          dispatch_op,
  input  logic [REG_W-1:0]         dispatch_rd,
  input  logic [NUM_SRC*TAG_W-1:0] dispatch_tag,
  input  logic                     dispatch_spec,
  output logic [NUM_FU-1:0]        dispatch_ready,
  input  logic                     wb_en,
  input  logic [FU_W-1:0]          wb_fu,
  input  logic                     branch_miss,
  input  logic                     branch_resolved,
  input  logic                     freeze,
  output logic [NUM_FU-1:0]        issue_valid,
  input  logic [NUM_FU-1:0]        issue_ready,
  output logic [NUM_FU*OP_W-1:0]   issue_op,
  output logic [NUM_FU*REG_W-1:0]  issue_rd,
  output logic [NUM_FU*2-1:0]      fust_state
);
  typedef struct packed {
    logic                              busy;
    logic                              issued;
    logic                              spec;
    logic [OP_W-1:0]                   op;
    logic [REG_W-1:0]                  rd;
    logic [NUM_SRC-1:0][TAG_W-1:0]     tags;
  } row_t;
  localparam logic [TAG_W-1:0] TAG_RDY = TAG_W'(TAG_READY);
  row_t [NUM_FU-1:0]             row_q, row_d;
  logic [NUM_FU-1:0]             ready;
  logic [NUM_SRC-1:0][TAG_W-1:0] disp_tags;
  logic [TAG_W-1:0]              wb_tag;
  fust_state_e                   st;
  assign wb_tag = TAG_W'(wb_fu) + TAG_W'(1);
  always_comb begin
    st = FUST_IDLE;
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i]          = row_q[i].busy && !row_q[i].issued && (row_q[i].tags == {NUM_SRC{TAG_RDY}});
      dispatch_ready[i] = !freeze && !row_q[i].busy;
      st = !row_q[i].busy ? FUST_IDLE : row_q[i].issued ? FUST_ISSUED : ready[i] ? FUST_READY : FUST_WAIT;
      fust_state[i*2 +: 2]       = st;
      issue_op[i*OP_W +: OP_W]    = row_q[i].op;
      issue_rd[i*REG_W +: REG_W]  = row_q[i].rd;
    end
  end
  fust_issue_select #(.NUM_FU(NUM_FU), .ISSUE_W(ISSUE_W)) u_sel (
    .req (freeze ? '0 : ready),
    .gnt (issue_valid)
  );
  // Later assignments take priority: free/squash over update, then a fresh dispatch into an idle row.
  always_comb begin
    row_d = row_q;
    for (int s = 0; s < NUM_SRC; s++)
      disp_tags[s] = (wb_en && dispatch_tag[s*TAG_W +: TAG_W] == wb_tag) ? TAG_RDY : dispatch_tag[s*TAG_W +: TAG_W];
    for (int i = 0; i < NUM_FU; i++) begin
      for (int s = 0; s < NUM_SRC; s++)
        row_d[i].tags[s] = (wb_en && row_q[i].tags[s] == wb_tag) ? TAG_RDY : row_q[i].tags[s];
      row_d[i].issued = row_q[i].issued || (issue_valid[i] && issue_ready[i]);
      row_d[i].spec   = row_q[i].spec && !(branch_resolved && !branch_miss);
      if ((wb_en && wb_fu == FU_W'(i)) || (branch_miss && row_q[i].spec))
        row_d[i] = '0;
      if (dispatch_en && dispatch_fu == FU_W'(i) && dispatch_ready[i] && !(branch_miss && dispatch_spec))
        row_d[i] = '{busy: 1'b1, issued: 1'b0, spec: dispatch_spec && !branch_resolved,
                     op: dispatch_op, rd: dispatch_rd, tags: disp_tags};
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) row_q <= '0;
    else       row_q <= row_d;
  end
endmodule

// File: tb/tb_fu_status_table.sv
// tb_fu_status_table: directed test-plan checks plus randomized run against an array-based model.
module tb_fu_status_table;
  localparam int N = 5, S = 3, OW = 8, RW = 5, IW = 2, FW = 3, TW = 3;
  logic          CLK = 1'b0, nRST;
  logic          dispatch_en, dispatch_spec, wb_en, branch_miss, branch_resolved, freeze;
  logic [FW-1:0] dispatch_fu, wb_fu;
  logic [OW-1:0] dispatch_op;
  logic [RW-1:0] dispatch_rd;
  logic [S*TW-1:0] dispatch_tag;
  logic [N-1:0]  dispatch_ready, issue_valid, issue_ready;
  logic [N*OW-1:0] issue_op;
  logic [N*RW-1:0] issue_rd;
  logic [N*2-1:0]  fust_state;
  int n_tests = 0, n_fail = 0;
  bit m_busy[N], m_iss[N], m_spec[N];
  int m_op[N], m_rd[N], m_tag[N][S];

  fu_status_table #(.NUM_FU(N), .NUM_SRC(S), .OP_W(OW), .REG_W(RW), .ISSUE_W(IW)) dut (
    .CLK(CLK), .nRST(nRST), .dispatch_en(dispatch_en), .dispatch_fu(dispatch_fu),
    .dispatch_op(dispatch_op), .dispatch_rd(dispatch_rd), .dispatch_tag(dispatch_tag),
    .dispatch_spec(dispatch_spec), .dispatch_ready(dispatch_ready), .wb_en(wb_en), .wb_fu(wb_fu),
    .branch_miss(branch_miss), .branch_resolved(branch_resolved), .freeze(freeze),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_rd(issue_rd), .fust_state(fust_state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready(input int i);
    m_ready = m_busy[i] && !m_iss[i] && m_tag[i][0] == 0 && m_tag[i][1] == 0 && m_tag[i][2] == 0;
  endfunction

  function automatic logic [N-1:0] m_valid();
    int c = 0;
    m_valid = '0;
    if (!freeze)
      for (int i = 0; i < N; i++)
        if (m_ready(i) && c < IW) begin
          m_valid[i] = 1'b1;
          c++;
        end
  endfunction

  function automatic int m_state(input int i);
    m_state = !m_busy[i] ? 0 : m_iss[i] ? 3 : m_ready(i) ? 2 : 1;
  endfunction

  task automatic m_clear(input int i);
    m_busy[i] = 0; m_iss[i] = 0; m_spec[i] = 0; m_op[i] = 0; m_rd[i] = 0;
    for (int s = 0; s < S; s++) m_tag[i][s] = 0;
  endtask

  task automatic check_all();
    logic [N-1:0] rdy;
    logic [N*2-1:0] st;
    logic [N*OW-1:0] op;
    logic [N*RW-1:0] rd;
    for (int i = 0; i < N; i++) begin
      rdy[i] = !freeze && !m_busy[i];
      st[i*2 +: 2] = 2'(m_state(i));
      op[i*OW +: OW] = OW'(m_op[i]);
      rd[i*RW +: RW] = RW'(m_rd[i]);
    end
    check("issue_valid", issue_valid, m_valid());
    check("dispatch_ready", dispatch_ready, rdy);
    check("fust_state", fust_state, st);
    check("issue_op", issue_op, op);
    check("issue_rd", issue_rd, rd);
  endtask

  task automatic model_step();
    logic [N-1:0] v = m_valid();
    bit ob[N] = m_busy;
    int wt = int'(wb_fu) + 1;
    int fu = int'(dispatch_fu);
    for (int i = 0; i < N; i++) begin
      for (int s = 0; s < S; s++) if (wb_en && m_tag[i][s] == wt) m_tag[i][s] = 0;
      if (v[i] && issue_ready[i]) m_iss[i] = 1;
      if (branch_resolved && !branch_miss) m_spec[i] = 0;
      if ((wb_en && int'(wb_fu) == i) || (branch_miss && m_spec[i])) m_clear(i);
    end
    if (dispatch_en && !freeze && fu < N && !ob[fu] && !(branch_miss && dispatch_spec)) begin
      m_busy[fu] = 1; m_iss[fu] = 0;
      m_spec[fu] = dispatch_spec && !branch_resolved;
      m_op[fu] = int'(dispatch_op); m_rd[fu] = int'(dispatch_rd);
      for (int s = 0; s < S; s++) begin
        m_tag[fu][s] = int'(dispatch_tag[s*TW +: TW]);
        if (wb_en && m_tag[fu][s] == wt) m_tag[fu][s] = 0;
      end
    end
  endtask

  task automatic step();
    #1 check_all();
    model_step();
    @(negedge CLK);
  endtask

  task automatic clr();
    dispatch_en = 0; dispatch_fu = '0; dispatch_op = '0; dispatch_rd = '0; dispatch_tag = '0;
    dispatch_spec = 0; wb_en = 0; wb_fu = '0; branch_miss = 0; branch_resolved = 0;
    freeze = 0; issue_ready = '0;
  endtask

  task automatic disp(input int fu, input int t0, input int t1, input int t2, input bit sp);
    dispatch_en = 1; dispatch_fu = FW'(fu); dispatch_spec = sp;
    dispatch_op = OW'($urandom); dispatch_rd = RW'($urandom);
    dispatch_tag = {TW'(t2), TW'(t1), TW'(t0)};
  endtask

  task automatic wb(input int fu);
    wb_en = 1; wb_fu = FW'(fu);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, issue_valid, '0);
    check({tag, "_op"}, issue_op, '0);
    check({tag, "_rd"}, issue_rd, '0);
    check({tag, "_state"}, fust_state, '0);
    check({tag, "_dready"}, dispatch_ready, 5'b11111);
  endtask

  initial begin
    clr();
    nRST = 0;
    for (int i = 0; i < N; i++) m_clear(i);
    #1 check_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1;
    // ready dispatch then issue handshake
    clr(); disp(2, 0, 0, 0, 0); issue_ready = 5'b00100; step();
    clr(); issue_ready = 5'b00100; #1 check("disp_issue_valid", issue_valid, 5'b00100); step();
    clr(); #1 check("disp_issued_state", fust_state[5:4], 2'd3); step();
    clr(); wb(2); step();
    // dependency wakeup
    clr(); disp(2, 0, 0, 0, 0); step();
    clr(); disp(1, 3, 0, 0, 0); step();
    clr(); wb(2); #1 check("wake_wait_state", fust_state[3:2], 2'd1); step();
    clr(); #1 check("wake_ready_state", fust_state[3:2], 2'd2);
    check("wake_free_state", fust_state[5:4], 2'd0); wb(1); step();
    // same-cycle bypass
    clr(); disp(0, 2, 0, 0, 0); wb(1); step();
    clr(); #1 check("bypass_state", fust_state[1:0], 2'd2); wb(0); step();
    // issue width
    foreach (m_busy[k]) if (k != 2) begin clr(); disp(k, 0, 0, 0, 0); step(); end
    clr(); issue_ready = 5'b11111; #1 check("width_first", issue_valid, 5'b00011); step();
    clr(); issue_ready = 5'b11111; #1 check("width_second", issue_valid, 5'b11000); step();
    foreach (m_busy[k]) if (k != 2) begin clr(); wb(k); step(); end
    // branch miss
    clr(); disp(3, 0, 0, 0, 1); step();
    clr(); disp(4, 1, 0, 0, 0); issue_ready = 5'b01000; step();
    clr(); branch_miss = 1; disp(0, 0, 0, 0, 1); step();
    clr(); #1 check("miss_row0", fust_state[1:0], 2'd0);
    check("miss_row3", fust_state[7:6], 2'd0);
    check("miss_row4", fust_state[9:8], 2'd1); wb(4); step();
    // freeze
    clr(); disp(0, 0, 0, 0, 0); step();
    clr(); disp(1, 0, 0, 0, 0); step();
    clr(); freeze = 1; wb(1); #1 check("freeze_valid", issue_valid, '0);
    check("freeze_dready", dispatch_ready, '0); step();
    clr(); freeze = 1; #1 check("freeze_wb_free", fust_state[3:2], 2'd0); step();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      clr();
      if ($urandom_range(0, 1) == 1) begin
        int t[S];
        foreach (t[s]) t[s] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0;
        disp(int'($urandom_range(0, N - 1)), t[0], t[1], t[2], 1'($urandom_range(0, 2) == 0));
      end
      if ($urandom_range(0, 9) < 3) wb(int'($urandom_range(0, N - 1)));
      branch_miss     = ($urandom_range(0, 19) == 0);
      branch_resolved = ($urandom_range(0, 9) == 0);
      freeze          = ($urandom_range(0, 9) == 0);
      issue_ready     = N'($urandom);
      step();
    end
    // asynchronous reset mid-run
    clr(); #2 nRST = 0;
    #1 check_reset_outputs("async_rst");
    for (int i = 0; i < N; i++) m_clear(i);
    @(negedge CLK);
    nRST = 1;
    clr(); disp(4, 0, 0, 0, 0); step();
    clr(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
